// File: rtl/baud_gen_frac_if.sv
// Bus bundle for the fractional baud generator.
// master: increment/control side (drives en, incr_in, incr_load, rx_restart)
// slave : the generator (drives incr_ack and the three tick outputs)
`timescale 1ns/1ps
interface baud_gen_frac_if #(
  parameter int ACC_WIDTH = 16
);
  logic                 en;
  logic [ACC_WIDTH-1:0] incr_in;
  logic                 incr_load;
  logic                 incr_ack;
  logic                 rx_restart;
  logic                 rxclk_en;
  logic                 txclk_en;
  logic                 rx_sample_en;

  modport master (
    output en, incr_in, incr_load, rx_restart,
    input  incr_ack, rxclk_en, txclk_en, rx_sample_en
  );

  modport slave (
    input  en, incr_in, incr_load, rx_restart,
    output incr_ack, rxclk_en, txclk_en, rx_sample_en
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator.
// A phase accumulator adds incr every enabled cycle; each carry out is one
// oversample tick (rxclk_en). Two oversample counters divide that down:
// tx_os gives the bit tick (txclk_en), rx_os gives the mid-bit sample tick
// (rx_sample_en) and can be realigned to a start-bit edge via rx_restart.
// Ports:
//   clk_12m      sole clock, rising edge
//   rst          synchronous active-high reset
//   bus.en       run enable (low freezes phase and counters)
//   bus.incr_in  new phase increment, captured on bus.incr_load
//   bus.incr_ack one-cycle pulse after a load
//   bus.rx_restart realign rx bit phase
//   bus.rxclk_en / bus.txclk_en / bus.rx_sample_en  registered ticks
// OVERSAMPLE must be a power of two >= 4 so the counters wrap naturally.
`timescale 1ns/1ps
module baud_gen_frac #(
  parameter int ACC_WIDTH    = 16,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_INCR = 10066
) (
  input  logic              clk_12m,
  input  logic              rst,
  baud_gen_frac_if.slave    bus
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [ACC_WIDTH-1:0] INCR_RST = ACC_WIDTH'(DEFAULT_INCR);

  logic [ACC_WIDTH-1:0] incr;
  logic [ACC_WIDTH-1:0] acc;
  logic [OS_W-1:0]      tx_os;
  logic [OS_W-1:0]      rx_os;
  logic                 rxclk_en_q;
  logic                 txclk_en_q;
  logic                 rx_sample_en_q;
  logic                 incr_ack_q;

  logic [ACC_WIDTH:0]   sum;
  logic                 carry;

  assign sum   = {1'b0, acc} + {1'b0, incr};
  assign carry = sum[ACC_WIDTH];

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      incr           <= INCR_RST;
      acc            <= '0;
      tx_os          <= '0;
      rx_os          <= '0;
      rxclk_en_q     <= 1'b0;
      txclk_en_q     <= 1'b0;
      rx_sample_en_q <= 1'b0;
      incr_ack_q     <= 1'b0;
    end else if (bus.incr_load) begin
      // A load restarts the phase from zero so the new rate takes effect
      // cleanly; it wins over rx_restart and ignores en.
      incr           <= bus.incr_in;
      acc            <= '0;
      tx_os          <= '0;
      rx_os          <= '0;
      rxclk_en_q     <= 1'b0;
      txclk_en_q     <= 1'b0;
      rx_sample_en_q <= 1'b0;
      incr_ack_q     <= 1'b1;
    end else begin
      incr_ack_q     <= 1'b0;
      rxclk_en_q     <= 1'b0;
      txclk_en_q     <= 1'b0;
      rx_sample_en_q <= 1'b0;
      if (bus.en) begin
        acc        <= sum[ACC_WIDTH-1:0];
        rxclk_en_q <= carry;
        if (carry) begin
          tx_os          <= tx_os + OS_W'(1);
          txclk_en_q     <= (tx_os == OS_LAST);
          rx_os          <= rx_os + OS_W'(1);
          rx_sample_en_q <= (rx_os == OS_MID);
        end
      end
      // Realignment overrides the rx counter update above, even when frozen.
      if (bus.rx_restart) begin
        rx_os          <= '0;
        rx_sample_en_q <= 1'b0;
      end
    end
  end

  assign bus.rxclk_en     = rxclk_en_q;
  assign bus.txclk_en     = txclk_en_q;
  assign bus.rx_sample_en = rx_sample_en_q;
  assign bus.incr_ack     = incr_ack_q;

endmodule
